// File: rtl/window_minmax_pkg.sv
// rtl/window_minmax_pkg.sv - shared types and sizing helpers for window_minmax
package window_minmax_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Rise counter needs to hold COUNT-1 at most; never narrower than one bit.
  function automatic int rw_of(input int count);
    int w;
    w = $clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int CNT_W = 8;

endpackage

// File: rtl/window_minmax_mag_cmp3.sv
// rtl/window_minmax_mag_cmp3.sv - unsigned magnitude comparator, gt/lt/eq
module mag_cmp3 #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/window_minmax.sv
// rtl/window_minmax.sv - per-window min/max/all-equal/rise-count summariser
module window_minmax
  import window_minmax_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int COUNT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_min,
  output logic [WIDTH-1:0]         out_max,
  output logic                     out_all_eq,
  output logic [rw_of(COUNT)-1:0]  out_rises
);

  localparam int RW = rw_of(COUNT);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   min_r, max_r, prev_r;
  logic [WIDTH-1:0]   min_n, max_n;
  logic [RW-1:0]      rises_r, rises_n;
  logic               all_eq_r;
  logic               accept, first, last;
  logic               lt_min, gt_max, gt_prev;
  logic               cmp_unused_min_gt, cmp_unused_min_eq;
  logic               cmp_unused_max_lt, cmp_unused_max_eq;
  logic               cmp_unused_prev_lt, cmp_unused_prev_eq;

  mag_cmp3 #(.WIDTH(WIDTH)) u_cmp_min (
    .a(in_data), .b(min_r),
    .gt(cmp_unused_min_gt), .lt(lt_min), .eq(cmp_unused_min_eq)
  );

  mag_cmp3 #(.WIDTH(WIDTH)) u_cmp_max (
    .a(in_data), .b(max_r),
    .gt(gt_max), .lt(cmp_unused_max_lt), .eq(cmp_unused_max_eq)
  );

  mag_cmp3 #(.WIDTH(WIDTH)) u_cmp_prev (
    .a(in_data), .b(prev_r),
    .gt(gt_prev), .lt(cmp_unused_prev_lt), .eq(cmp_unused_prev_eq)
  );

  assign accept = in_valid && (state == ACCUM);
  assign first  = (cnt == '0);
  assign last   = (cnt == CNT_W'(COUNT - 1));

  // The first sample of a window seeds every tracker; later ones update on strict compares only.
  assign min_n   = (first || lt_min) ? in_data : min_r;
  assign max_n   = (first || gt_max) ? in_data : max_r;
  assign rises_n = first ? '0 : (rises_r + RW'(gt_prev));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last) state_n = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      min_r    <= '0;
      max_r    <= '0;
      prev_r   <= '0;
      rises_r  <= '0;
      all_eq_r <= 1'b0;
    end else if (accept) begin
      min_r   <= min_n;
      max_r   <= max_n;
      prev_r  <= in_data;
      rises_r <= rises_n;
      if (last) begin
        cnt      <= '0;
        all_eq_r <= (min_n == max_n);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out_min    = min_r;
  assign out_max    = max_r;
  assign out_all_eq = all_eq_r;
  assign out_rises  = rises_r;

endmodule

// File: tb/tb_window_minmax.sv
// tb/tb_window_minmax.sv - directed self-checking bench for window_minmax
module tb_window_minmax;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] in_data, out_min, out_max;
  logic       out_all_eq;
  logic [1:0] out_rises;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [2:0] in_data1, out_min1, out_max1;
  logic       out_all_eq1;
  logic [0:0] out_rises1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  window_minmax #(.WIDTH(3), .COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max),
    .out_all_eq(out_all_eq), .out_rises(out_rises)
  );

  window_minmax #(.WIDTH(3), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_min(out_min1), .out_max(out_max1),
    .out_all_eq(out_all_eq1), .out_rises(out_rises1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [2:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_sum(input string tag, input int mn, input int mx, input int eq, input int r);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_min"}, out_min, mn);
    check({tag, "_max"}, out_max, mx);
    check({tag, "_eq"}, out_all_eq, eq);
    check({tag, "_rises"}, out_rises, r);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_min", out_min, 0);
    check("rst_max", out_max, 0);
    check("rst_eq", out_all_eq, 0);
    check("rst_rises", out_rises, 0);
    check("rst1_in_ready", in_ready1, 1);

    // 5,2,7,2
    out_ready = 1'b1;
    send(3'd5); send(3'd2); send(3'd7);
    check("w1_pre_valid", out_valid, 0);
    send(3'd2);
    check_sum("w1", 2, 7, 0, 1);
    check("w1_in_ready", in_ready, 0);

    // 3,3,3,3
    send(3'd3); send(3'd3); send(3'd3); send(3'd3);
    check_sum("w2", 3, 3, 1, 0);

    // 0,1,2,3 with idle gaps
    send(3'd0); idle(2); send(3'd1); idle(2); send(3'd2); idle(2);
    check("w3_pre_valid", out_valid, 0);
    send(3'd3);
    check_sum("w3", 0, 3, 0, 3);

    // Backpressure: hold summary of 1,1,1,1 while producer offers 6
    send(3'd1); send(3'd1); send(3'd1);
    out_ready = 1'b0;
    send(3'd1);
    check_sum("w4", 1, 1, 1, 0);
    in_valid = 1'b1; in_data = 3'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_min", out_min, 1);
      check("bp_max", out_max, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_exit_valid", out_valid, 0);
    check("bp_exit_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    send(3'd5); send(3'd5);
    check("w5_pre_valid", out_valid, 0);
    send(3'd5);
    check_sum("w5", 5, 6, 0, 0);

    // Mid-window reset
    send(3'd1); send(3'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 1);
    send(3'd4); send(3'd4); send(3'd0);
    check("w6_pre_valid", out_valid, 0);
    send(3'd7);
    check_sum("w6", 0, 7, 0, 1);
    @(negedge clk);

    // COUNT=1 instance
    in_valid1 = 1'b1; in_data1 = 3'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    check("c1_valid", out_valid1, 1);
    check("c1_min", out_min1, 5);
    check("c1_max", out_max1, 5);
    check("c1_eq", out_all_eq1, 1);
    check("c1_rises", out_rises1, 0);
    check("c1_ready", in_ready1, 0);
    @(negedge clk);
    check("c1_hold_ready", in_ready1, 0);
    check("c1_hold_valid", out_valid1, 1);
    out_ready1 = 1'b1;
    @(negedge clk);
    check("c1_exit_valid", out_valid1, 0);
    check("c1_exit_ready", in_ready1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
